// File: rtl/tag_queue_mp_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tag_queue_mp_if : push/pop/status bundle for tag_queue_mp                |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface tag_queue_mp_if #(
  parameter int DEPTH      = 8,
  parameter int TAG_WIDTH  = 4,
  parameter int PUSH_PORTS = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                            flush;
  logic [PUSH_PORTS-1:0]           push_valid;
  logic [PUSH_PORTS*TAG_WIDTH-1:0] push_tag;
  logic                            push_ready;
  logic                            pop;
  logic                            front_valid;
  logic [TAG_WIDTH-1:0]            front_tag;
  logic [CW-1:0]                   count;
  logic                            empty;
  logic                            full;
  logic                            err_overflow;
  logic                            err_underflow;

  modport master (
    output flush, push_valid, push_tag, pop,
    input  push_ready, front_valid, front_tag, count, empty, full,
           err_overflow, err_underflow
  );

  modport slave (
    input  flush, push_valid, push_tag, pop,
    output push_ready, front_valid, front_tag, count, empty, full,
           err_overflow, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/tag_queue_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tag_queue_mp : multi-push in-order tag queue, single pop, sync flush.    |
// | Define TAG_QUEUE_BYPASS_EN for the empty-queue port-0 bypass.            |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tag_queue_mp #(
  parameter int DEPTH      = 8,
  parameter int TAG_WIDTH  = 4,
  parameter int PUSH_PORTS = 2
) (
  input  wire logic     clk,
  input  wire logic     reset,
  tag_queue_mp_if.slave bus
);
  localparam int PW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int MAX_FILL = DEPTH - PUSH_PORTS;

  logic [TAG_WIDTH-1:0] mem_q [DEPTH];
  logic [TAG_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 err_ovf_q, err_ovf_d;
  logic                 err_unf_q, err_unf_d;

  logic                 occupied;
  logic                 push_ready;
  logic                 push_any;
  logic                 accept;
  logic                 bypass_act;
  logic                 bypass_pop;
  logic                 mem_pop;
  logic                 front_valid;
  logic [TAG_WIDTH-1:0] front_tag;

  // Explicit modulo-DEPTH add so non-power-of-two depths wrap correctly.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr,
                                            input int unsigned k);
    int unsigned s;
    s = 32'(ptr) + k;
    if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
    return PW'(s);
  endfunction

  assign occupied   = (count_q != '0);
  assign push_ready = (32'(count_q) <= 32'(MAX_FILL));
  assign push_any   = |bus.push_valid;
  assign accept     = push_ready & ~bus.flush;

`ifdef TAG_QUEUE_BYPASS_EN
  assign bypass_act = ~occupied & accept & bus.push_valid[0];
`else
  assign bypass_act = 1'b0;
`endif

  assign bypass_pop  = bypass_act & bus.pop;
  assign mem_pop     = occupied & bus.pop & ~bus.flush;
  assign front_valid = occupied | bypass_act;

  always_comb begin
    front_tag = '0;
    if (occupied)
      front_tag = mem_q[head_q];
    else if (bypass_act)
      front_tag = bus.push_tag[TAG_WIDTH-1:0];
  end

  always_comb begin
    int unsigned n_wr;
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    n_wr      = 0;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_any && !push_ready) err_ovf_d = 1'b1;
      if (bus.pop && !front_valid) err_unf_d = 1'b1;
      // Valid ports are packed in ascending order; a bypassed port 0 is never stored.
      if (accept) begin
        for (int i = 0; i < PUSH_PORTS; i++) begin
          if (bus.push_valid[i] && !(i == 0 && bypass_pop)) begin
            mem_d[ptr_add(tail_q, n_wr)] = bus.push_tag[i*TAG_WIDTH +: TAG_WIDTH];
            n_wr = n_wr + 1;
          end
        end
      end
      tail_d = ptr_add(tail_q, n_wr);
      if (mem_pop) head_d = ptr_add(head_q, 32'd1);
      count_d = CW'(32'(count_q) + n_wr - 32'(mem_pop));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign bus.push_ready    = push_ready;
  assign bus.front_valid   = front_valid;
  assign bus.front_tag     = front_tag;
  assign bus.count         = count_q;
  assign bus.empty         = ~occupied;
  assign bus.full          = (count_q == CW'(DEPTH));
  assign bus.err_overflow  = err_ovf_q;
  assign bus.err_underflow = err_unf_q;
endmodule
`default_nettype wire
